inport_gearbox: RTL and testbench
=================================

// Module: inport_gearbox
// PURPOSE
//  Upstream neighbour of the PHV input port. Accepts a narrow valid/ready beat stream and
//  packs RATIO beats into one 1024-bit word, then presents it as io_en/io_last/io_data.
//  The PHV port splits io_data into 128 bytes; byte 0 is io_data[1023:1016].
//  A short or partial packet tail is zero-padded. io_hold stalls the output and
//  back-pressures the input.
// PARAMETERS
//  IN_W    256   input beat width (bits); must divide OUT_W
//  OUT_W   1024  output word width (bits); matches the PHV port data width
//  RATIO   4     OUT_W/IN_W beats per word (derived, not overridable)
//  CNT_W   32    packet counter width
// PORTS
//  clock          in   1      single clock; all logic on rising edge
//  reset          in   1      synchronous, active-high
//  io_in_valid    in   1      input beat valid
//  io_in_ready    out  1      input beat ready
//  io_in_data     in   IN_W   beat payload; MSB = earliest byte
//  io_in_last     in   1      beat is the final beat of the packet
//  io_hold        in   1      downstream stall; output word is not consumed this cycle
//  io_en          out  1      output word valid; drives PHV port io_en
//  io_last        out  1      output word ends the packet; drives PHV port io_last
//  io_data        out  OUT_W  assembled word; drives PHV port io_data
//  io_pkt_count   out  CNT_W  number of packets fully emitted (wraps)
// BEHAVIOUR
//  - State:
//      beat_cnt (0..RATIO-1)
//      acc: OUT_W assembly register
//      acc_full flag
//      output register (o_valid, o_last, o_data)
//      pkt counter
//  - Reset: all state 0. io_en=0, io_last=0, io_data=0, io_pkt_count=0, io_in_ready=1.
//    Beats presented while reset=1 are dropped.
//  - Reset mid-packet discards the partial word and any held output; no padded word is emitted.
//  - Handshake:
//      accept  = io_in_valid & io_in_ready
//      io_in_ready = !acc_full (registered, no combinational path from io_hold)
//  - Lane mapping: beat k of a word occupies bits [OUT_W-1-k*IN_W -: IN_W].
//  - Word complete: accept with beat_cnt==RATIO-1, or accept with io_in_last=1.
//      - Lanes beyond the last accepted beat are 0 in the emitted word.
//      - beat_cnt returns to 0. Otherwise beat_cnt increments on each accept.
//  - Output slot free: !o_valid | !io_hold.
//      - A word is consumed on any cycle with o_valid & !io_hold.
//      - If not consumed, o_valid/o_last/o_data hold unchanged.
//  - Word complete in cycle N and slot free:
//      - The word loads the output register at the edge.
//      - io_en=1 in cycle N+1. Latency from the completing beat to io_en is 1 cycle.
//  - Word complete and slot not free:
//      - The word stays in acc and acc_full=1, so io_in_ready=0 from N+1.
//      - In the first cycle the slot is free, acc transfers and acc_full clears.
//      - io_in_ready returns to 1 in the following cycle.
//  - Slot free and no word is transferring: o_valid goes 0 at the edge. o_data/o_last may
//    hold stale values; checkers ignore them while io_en=0.
//  - Throughput with io_hold=0: one beat per cycle sustained. No bubbles at word or
//    packet boundaries.
//  - io_pkt_count increments by 1 when a word with o_last=1 is consumed. It wraps
//    2^CNT_W-1 -> 0.
//  - io_last=0 on every word of a packet except the final one.
//    io_in_last=1 on the first beat produces a 1-lane word with io_last=1.
// TESTING
//  T1: 4 beats A0..A3 (each beat = its index repeated per byte), last on beat 3, hold=0
//      -> one io_en pulse the cycle after beat 3; io_data={A0,A1,A2,A3}; io_last=1; pkt_count=1.
//  T2: 6-beat packet B0..B5 back-to-back
//      -> word1={B0..B3}, io_last=0; word2={B4,B5,256'h0,256'h0}, io_last=1; io_in_ready
//         constantly 1; pkt_count=1.
//  T3: single beat C0 with last
//      -> io_data={C0,768'h0}, io_last=1, io_en high exactly 1 cycle.
//  T4: 12 beats streamed with io_hold=1 for 6 cycles starting at the first io_en
//      -> io_data stable during hold; io_in_ready drops after the second word completes;
//         no beat lost or duplicated; 3 words delivered in order.
//  T5: reset asserted after 2 beats of a packet, then a fresh 4-beat packet
//      -> no output for the partial; fresh word correct; pkt_count=1.
//  T6: 3 single-beat packets, valid toggling 1/0 each cycle
//      -> 3 io_en pulses, each io_last=1; pkt_count=3.

Source files
------------

// File: rtl/inport_gearbox.sv
`default_nettype none
// ============================================================================
//  Module      : inport_gearbox
//  Description : Packs RATIO narrow valid/ready beats into one OUT_W-bit word
//                for the PHV input port. Beat k of a word lands in bits
//                [OUT_W-1-k*IN_W -: IN_W], so the earliest byte is byte 0 of
//                the PHV word. A packet tail shorter than RATIO beats is
//                zero-padded. io_hold stalls the output register and, once
//                the assembly register is also full, back-pressures the input.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock        in   1      rising-edge clock
//    reset        in   1      synchronous, active-high
//    io_in_valid  in   1      input beat valid
//    io_in_ready  out  1      input beat ready (registered)
//    io_in_data   in   IN_W   beat payload, MSB = earliest byte
//    io_in_last   in   1      final beat of the packet
//    io_hold      in   1      downstream stall; word not consumed this cycle
//    io_en        out  1      output word valid
//    io_last      out  1      output word ends the packet
//    io_data      out  OUT_W  assembled word
//    io_pkt_count out  CNT_W  packets fully emitted (wraps)
// ============================================================================
module inport_gearbox #(
   parameter int IN_W  = 256,
   parameter int OUT_W = 1024,
   parameter int CNT_W = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             io_in_valid,
   output logic             io_in_ready,
   input  logic [IN_W-1:0]  io_in_data,
   input  logic             io_in_last,
   input  logic             io_hold,
   output logic             io_en,
   output logic             io_last,
   output logic [OUT_W-1:0] io_data,
   output logic [CNT_W-1:0] io_pkt_count
);

   // IN_W must divide OUT_W; the ratio is derived and cannot be overridden.
   localparam int RATIO = OUT_W / IN_W;
   localparam int BW    = (RATIO > 1) ? $clog2(RATIO) : 1;

   logic [BW-1:0]    r_beat_cnt;
   logic [OUT_W-1:0] r_acc;
   logic             r_acc_last;
   logic             r_acc_full;
   logic             r_o_valid;
   logic             r_o_last;
   logic [OUT_W-1:0] r_o_data;
   logic [CNT_W-1:0] r_pkt_cnt;

   logic             w_accept;
   logic             w_complete;
   logic             w_slot_free;
   logic [OUT_W-1:0] w_acc_next;

   assign w_accept    = io_in_valid & ~r_acc_full;
   assign w_complete  = w_accept & ((r_beat_cnt == BW'(RATIO - 1)) | io_in_last);
   assign w_slot_free = ~r_o_valid | ~io_hold;

   // Next assembly value: earlier lanes keep their beats, the current lane
   // takes the incoming beat, and later lanes are forced to zero. Building the
   // zero padding here means the accumulator never needs an explicit clear.
   for (genvar j = 0; j < RATIO; j++) begin : g_lane
      assign w_acc_next[OUT_W-1-j*IN_W -: IN_W] =
         (BW'(j) == r_beat_cnt) ? io_in_data :
         (BW'(j) <  r_beat_cnt) ? r_acc[OUT_W-1-j*IN_W -: IN_W] :
                                  {IN_W{1'b0}};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_beat_cnt <= '0;
         r_acc      <= '0;
         r_acc_last <= 1'b0;
         r_acc_full <= 1'b0;
         r_o_valid  <= 1'b0;
         r_o_last   <= 1'b0;
         r_o_data   <= '0;
         r_pkt_cnt  <= '0;
      end else begin
         if (r_o_valid & ~io_hold & r_o_last) begin
            r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
         end

         if (r_acc_full) begin
            // Input is stalled; drain the parked word as soon as the slot opens.
            if (w_slot_free) begin
               r_o_valid  <= 1'b1;
               r_o_last   <= r_acc_last;
               r_o_data   <= r_acc;
               r_acc_full <= 1'b0;
            end
         end else if (w_complete) begin
            r_beat_cnt <= '0;
            if (w_slot_free) begin
               // Bypass the accumulator so the word appears one cycle later.
               r_o_valid <= 1'b1;
               r_o_last  <= io_in_last;
               r_o_data  <= w_acc_next;
            end else begin
               r_acc      <= w_acc_next;
               r_acc_last <= io_in_last;
               r_acc_full <= 1'b1;
            end
         end else begin
            if (w_accept) begin
               r_acc      <= w_acc_next;
               r_beat_cnt <= r_beat_cnt + BW'(1);
            end
            if (w_slot_free) begin
               r_o_valid <= 1'b0;
            end
         end
      end
   end

   assign io_in_ready  = ~r_acc_full;
   assign io_en        = r_o_valid;
   assign io_last      = r_o_last;
   assign io_data      = r_o_data;
   assign io_pkt_count = r_pkt_cnt;

endmodule
`default_nettype wire

// File: tb/tb_inport_gearbox.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inport_gearbox
//  Description : Table-driven bench for inport_gearbox. Each table row is one
//                clock cycle: the inputs driven in that cycle and the outputs
//                expected to be visible in that same cycle. All beats are a
//                single byte value repeated across the lane, so an expected
//                word is described by four lane bytes (00 = padded lane).
//                The packet counter is narrowed to 3 bits to reach the wrap.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_inport_gearbox;

   localparam int IN_W  = 256;
   localparam int OUT_W = 1024;
   localparam int CNT_W = 3;

   logic             clock = 1'b0;
   logic             reset;
   logic             io_in_valid;
   logic             io_in_ready;
   logic [IN_W-1:0]  io_in_data;
   logic             io_in_last;
   logic             io_hold;
   logic             io_en;
   logic             io_last;
   logic [OUT_W-1:0] io_data;
   logic [CNT_W-1:0] io_pkt_count;

   inport_gearbox #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
      .clock        (clock),
      .reset        (reset),
      .io_in_valid  (io_in_valid),
      .io_in_ready  (io_in_ready),
      .io_in_data   (io_in_data),
      .io_in_last   (io_in_last),
      .io_hold      (io_hold),
      .io_en        (io_en),
      .io_last      (io_last),
      .io_data      (io_data),
      .io_pkt_count (io_pkt_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        rst;
      logic        v;
      logic        l;
      logic        h;
      logic [7:0]  b;
      logic        rdy;
      logic        en;
      logic        el;
      logic [31:0] lanes;
      logic [2:0]  cnt;
   } vec_t;

   vec_t tbl[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic add(input logic rst, input logic v, input logic l, input logic h,
                      input logic [7:0] b, input logic rdy, input logic en,
                      input logic el, input logic [31:0] lanes, input logic [2:0] cnt);
      vec_t t;
      t.rst = rst; t.v = v; t.l = l; t.h = h; t.b = b;
      t.rdy = rdy; t.en = en; t.el = el; t.lanes = lanes; t.cnt = cnt;
      tbl.push_back(t);
   endtask

   task automatic chk(input string nm, input logic [IN_W-1:0] act, input logic [IN_W-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   function automatic logic [IN_W-1:0] beat(input logic [7:0] b);
      return {(IN_W/8){b}};
   endfunction

   task automatic chk_word(input string nm, input logic [31:0] lanes);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("%s lane%0d", nm, k), io_data[OUT_W-1-k*IN_W -: IN_W],
             beat(lanes[31-8*k -: 8]));
      end
   endtask

   initial begin
      // T1: one full 4-beat packet
      add(0,1,0,0,8'hA0, 1,0,0,32'h0,0);
      add(0,1,0,0,8'hA1, 1,0,0,32'h0,0);
      add(0,1,0,0,8'hA2, 1,0,0,32'h0,0);
      add(0,1,1,0,8'hA3, 1,0,0,32'h0,0);
      add(0,0,0,0,8'h00, 1,1,1,32'hA0A1A2A3,0);
      add(0,0,0,0,8'h00, 1,0,0,32'h0,1);
      // T2: 6-beat packet, back-to-back
      add(0,1,0,0,8'hB0, 1,0,0,32'h0,1);
      add(0,1,0,0,8'hB1, 1,0,0,32'h0,1);
      add(0,1,0,0,8'hB2, 1,0,0,32'h0,1);
      add(0,1,0,0,8'hB3, 1,0,0,32'h0,1);
      add(0,1,0,0,8'hB4, 1,1,0,32'hB0B1B2B3,1);
      add(0,1,1,0,8'hB5, 1,0,0,32'h0,1);
      add(0,0,0,0,8'h00, 1,1,1,32'hB4B50000,1);
      add(0,0,0,0,8'h00, 1,0,0,32'h0,2);
      // T3: single beat packet
      add(0,1,1,0,8'hC0, 1,0,0,32'h0,2);
      add(0,0,0,0,8'h00, 1,1,1,32'hC0000000,2);
      // T6: three single-beat packets, valid toggling
      add(0,1,1,0,8'hD0, 1,0,0,32'h0,3);
      add(0,0,0,0,8'h00, 1,1,1,32'hD0000000,3);
      add(0,1,1,0,8'hD1, 1,0,0,32'h0,4);
      add(0,0,0,0,8'h00, 1,1,1,32'hD1000000,4);
      add(0,1,1,0,8'hD2, 1,0,0,32'h0,5);
      add(0,0,0,0,8'h00, 1,1,1,32'hD2000000,5);
      add(0,0,0,0,8'h00, 1,0,0,32'h0,6);
      // T4: 12 beats, hold for 6 cycles from the first io_en
      add(0,1,0,0,8'hE0, 1,0,0,32'h0,6);
      add(0,1,0,0,8'hE1, 1,0,0,32'h0,6);
      add(0,1,0,0,8'hE2, 1,0,0,32'h0,6);
      add(0,1,0,0,8'hE3, 1,0,0,32'h0,6);
      add(0,1,0,1,8'hE4, 1,1,0,32'hE0E1E2E3,6);
      add(0,1,0,1,8'hE5, 1,1,0,32'hE0E1E2E3,6);
      add(0,1,0,1,8'hE6, 1,1,0,32'hE0E1E2E3,6);
      add(0,1,0,1,8'hE7, 1,1,0,32'hE0E1E2E3,6);
      add(0,1,0,1,8'hE8, 0,1,0,32'hE0E1E2E3,6);
      add(0,1,0,1,8'hE8, 0,1,0,32'hE0E1E2E3,6);
      add(0,1,0,0,8'hE8, 0,1,0,32'hE0E1E2E3,6);
      add(0,1,0,0,8'hE8, 1,1,0,32'hE4E5E6E7,6);
      add(0,1,0,0,8'hE9, 1,0,0,32'h0,6);
      add(0,1,0,0,8'hEA, 1,0,0,32'h0,6);
      add(0,1,1,0,8'hEB, 1,0,0,32'h0,6);
      add(0,0,0,0,8'h00, 1,1,1,32'hE8E9EAEB,6);
      add(0,0,0,0,8'h00, 1,0,0,32'h0,7);
      // Counter wrap 7 -> 0
      add(0,1,1,0,8'h5A, 1,0,0,32'h0,7);
      add(0,0,0,0,8'h00, 1,1,1,32'h5A000000,7);
      add(0,0,0,0,8'h00, 1,0,0,32'h0,0);
      // T5: reset after two beats (beat offered during reset is dropped)
      add(0,1,0,0,8'hF0, 1,0,0,32'h0,0);
      add(0,1,0,0,8'hF1, 1,0,0,32'h0,0);
      add(1,1,0,0,8'hF2, 1,0,0,32'h0,0);
      add(0,0,0,0,8'h00, 1,0,0,32'h0,0);
      add(0,1,0,0,8'h61, 1,0,0,32'h0,0);
      add(0,1,0,0,8'h62, 1,0,0,32'h0,0);
      add(0,1,0,0,8'h63, 1,0,0,32'h0,0);
      add(0,1,1,0,8'h64, 1,0,0,32'h0,0);
      add(0,0,0,0,8'h00, 1,1,1,32'h61626364,0);
      add(0,0,0,0,8'h00, 1,0,0,32'h0,1);

      reset       = 1'b1;
      io_in_valid = 1'b0;
      io_in_last  = 1'b0;
      io_in_data  = '0;
      io_hold     = 1'b0;
      repeat (3) @(negedge clock);

      // Reset state
      chk("reset io_en",        IN_W'(io_en),        '0);
      chk("reset io_last",      IN_W'(io_last),      '0);
      chk("reset io_in_ready",  IN_W'(io_in_ready),  IN_W'(1));
      chk("reset io_pkt_count", IN_W'(io_pkt_count), '0);
      chk_word("reset io_data", 32'h0);

      for (int i = 0; i < tbl.size(); i++) begin
         if (i != 0) @(negedge clock);
         reset       = tbl[i].rst;
         io_in_valid = tbl[i].v;
         io_in_last  = tbl[i].l;
         io_hold     = tbl[i].h;
         io_in_data  = beat(tbl[i].b);
         chk($sformatf("row%0d io_en", i),        IN_W'(io_en),        IN_W'(tbl[i].en));
         chk($sformatf("row%0d io_in_ready", i),  IN_W'(io_in_ready),  IN_W'(tbl[i].rdy));
         chk($sformatf("row%0d io_pkt_count", i), IN_W'(io_pkt_count), IN_W'(tbl[i].cnt));
         if (tbl[i].en) begin
            chk($sformatf("row%0d io_last", i), IN_W'(io_last), IN_W'(tbl[i].el));
            chk_word($sformatf("row%0d io_data", i), tbl[i].lanes);
         end
      end

      @(negedge clock);
      io_in_valid = 1'b0;
      reset       = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
